// File: rtl/tictactoe_pkg.sv
// Shared types and lookup tables for the tic-tac-toe game sequencer.
// Cell codes, FSM states, screen edge tables and the eight winning lines.
package tictactoe_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      MARK_X = 2'b01,
      MARK_O = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      PLAY,
      CHECK,
      WIN,
      DRAW
   } state_t;

   localparam logic [15:0] X_EDGE [0:3] = '{
      16'd0, 16'd213, 16'd426, 16'd640
   };

   localparam logic [9:0] Y_EDGE [0:3] = '{
      10'd0, 10'd160, 10'd320, 10'd480
   };

   localparam logic [3:0] WIN_LINES [8][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic [3:0] cellIdx(
      input logic [1:0] row,
      input logic [1:0] col
   );
      return ({2'b00, row} * 4'd3) + {2'b00, col};
   endfunction

endpackage

// File: rtl/tictactoe_win_check.sv
// Combinational line detector: lineHit is set when any row, column or
// diagonal of board holds mark in all three cells.
module tictactoe_win_check
   import tictactoe_pkg::*;
(
   input  cell_t board [9],
   input  cell_t mark,
   output logic  lineHit
);

   always_comb begin
      lineHit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (board[WIN_LINES[i][0]] == mark &&
             board[WIN_LINES[i][1]] == mark &&
             board[WIN_LINES[i][2]] == mark)
            lineHit = 1'b1;
      end
   end

endmodule

// File: rtl/tictactoe_game_fsm.sv
// Tic-tac-toe game sequencer: board, cursor, turns, turn timer, win/draw.
// Ports: clk/rst, btn_* pulses in; pos1..pos9, sel_* rectangle, turn, winner, game_over out.
module tictactoe_game_fsm
   import tictactoe_pkg::*;
#(
   parameter logic [31:0] TURN_CYCLES = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_place,
   output logic [1:0]  pos1,
   output logic [1:0]  pos2,
   output logic [1:0]  pos3,
   output logic [1:0]  pos4,
   output logic [1:0]  pos5,
   output logic [1:0]  pos6,
   output logic [1:0]  pos7,
   output logic [1:0]  pos8,
   output logic [1:0]  pos9,
   output logic [15:0] sel_startX,
   output logic [15:0] sel_endX,
   output logic [9:0]  sel_startY,
   output logic [9:0]  sel_endY,
   output logic        turn,
   output logic [1:0]  winner,
   output logic        game_over
);

   state_t      state;
   cell_t       board [9];
   logic [1:0]  row;
   logic [1:0]  col;
   logic [31:0] timer;

   logic [1:0]  nextRow;
   logic [1:0]  nextCol;
   logic [3:0]  curIdx;
   logic [3:0]  emptyIdx;
   logic [3:0]  placeIdx;
   logic        found;
   logic        full;
   logic        autoFire;
   logic        doPlace;
   logic        lineHit;
   cell_t       mark;

   assign pos1 = board[0];
   assign pos2 = board[1];
   assign pos3 = board[2];
   assign pos4 = board[3];
   assign pos5 = board[4];
   assign pos6 = board[5];
   assign pos7 = board[6];
   assign pos8 = board[7];
   assign pos9 = board[8];

   assign mark   = turn ? MARK_O : MARK_X;
   assign curIdx = cellIdx(row, col);

   tictactoe_win_check uWinCheck (
      .board   (board),
      .mark    (mark),
      .lineHit (lineHit)
   );

   always_comb begin
      emptyIdx = 4'd0;
      found    = 1'b0;
      full     = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (board[i] == EMPTY) begin
            full = 1'b0;
            if (!found) begin
               emptyIdx = 4'(i);
               found    = 1'b1;
            end
         end
      end
   end

   // The timeout only fires when the player did not press place that cycle.
   assign autoFire = (TURN_CYCLES != 32'd0) &&
                     (timer == TURN_CYCLES - 32'd1) &&
                     !btn_place;

   assign placeIdx = btn_place ? curIdx : emptyIdx;

   assign doPlace = (state == PLAY) &&
                    ((btn_place && board[curIdx] == EMPTY) ||
                     autoFire);

   always_comb begin
      nextRow = row;
      nextCol = col;
      if (state == PLAY && !btn_place && !autoFire) begin
         if (btn_up)
            nextRow = (row == 2'd0) ? 2'd2 : row - 2'd1;
         else if (btn_down)
            nextRow = (row == 2'd2) ? 2'd0 : row + 2'd1;
         else if (btn_left)
            nextCol = (col == 2'd0) ? 2'd2 : col - 2'd1;
         else if (btn_right)
            nextCol = (col == 2'd2) ? 2'd0 : col + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PLAY;
         for (int i = 0; i < 9; i++)
            board[i] <= EMPTY;
         row        <= 2'd0;
         col        <= 2'd0;
         sel_startX <= X_EDGE[0];
         sel_endX   <= X_EDGE[1];
         sel_startY <= Y_EDGE[0];
         sel_endY   <= Y_EDGE[1];
         turn       <= 1'b0;
         winner     <= 2'b00;
         game_over  <= 1'b0;
         timer      <= 32'd0;
      end else begin
         unique case (state)
            PLAY: begin
               row        <= nextRow;
               col        <= nextCol;
               sel_startX <= X_EDGE[nextCol];
               sel_endX   <= X_EDGE[nextCol + 2'd1];
               sel_startY <= Y_EDGE[nextRow];
               sel_endY   <= Y_EDGE[nextRow + 2'd1];
               timer      <= timer + 32'd1;
               if (doPlace) begin
                  board[placeIdx] <= mark;
                  state           <= CHECK;
               end
            end
            CHECK: begin
               if (lineHit) begin
                  winner    <= mark;
                  game_over <= 1'b1;
                  state     <= WIN;
               end else if (full) begin
                  game_over <= 1'b1;
                  state     <= DRAW;
               end else begin
                  turn  <= ~turn;
                  timer <= 32'd0;
                  state <= PLAY;
               end
            end
            WIN, DRAW: begin
               if (btn_place) begin
                  for (int i = 0; i < 9; i++)
                     board[i] <= EMPTY;
                  row        <= 2'd0;
                  col        <= 2'd0;
                  sel_startX <= X_EDGE[0];
                  sel_endX   <= X_EDGE[1];
                  sel_startY <= Y_EDGE[0];
                  sel_endY   <= Y_EDGE[1];
                  turn       <= 1'b0;
                  winner     <= 2'b00;
                  game_over  <= 1'b0;
                  timer      <= 32'd0;
                  state      <= PLAY;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tictactoe_game_fsm.sv
// Bench for tictactoe_game_fsm: directed games plus random button traffic
// against a board-level reference model; a second instance exercises the turn timer.
module tb_tictactoe_game_fsm;

   logic clk = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;
   logic bUp = 1'b0, bDown = 1'b0, bLeft = 1'b0, bRight = 1'b0, bPlace = 1'b0;

   wire [17:0] posA;
   wire [15:0] sxA, exA;
   wire [9:0]  syA, eyA;
   wire        turnA, overA;
   wire [1:0]  winA;

   wire [17:0] posB;
   wire [15:0] sxB, exB;
   wire [9:0]  syB, eyB;
   wire        turnB, overB;
   wire [1:0]  winB;

   int nTests = 0;
   int nFail = 0;

   int mb [9];
   int mr, mc, mturn, mwin, mover;

   always #5 clk = ~clk;

   tictactoe_game_fsm #(.TURN_CYCLES(32'd0)) dut (
      .clk(clk), .rst(rstA),
      .btn_up(bUp), .btn_down(bDown), .btn_left(bLeft),
      .btn_right(bRight), .btn_place(bPlace),
      .pos1(posA[1:0]), .pos2(posA[3:2]), .pos3(posA[5:4]),
      .pos4(posA[7:6]), .pos5(posA[9:8]), .pos6(posA[11:10]),
      .pos7(posA[13:12]), .pos8(posA[15:14]), .pos9(posA[17:16]),
      .sel_startX(sxA), .sel_endX(exA),
      .sel_startY(syA), .sel_endY(eyA),
      .turn(turnA), .winner(winA), .game_over(overA)
   );

   tictactoe_game_fsm #(.TURN_CYCLES(32'd16)) dutT (
      .clk(clk), .rst(rstB),
      .btn_up(1'b0), .btn_down(1'b0), .btn_left(1'b0),
      .btn_right(1'b0), .btn_place(1'b0),
      .pos1(posB[1:0]), .pos2(posB[3:2]), .pos3(posB[5:4]),
      .pos4(posB[7:6]), .pos5(posB[9:8]), .pos6(posB[11:10]),
      .pos7(posB[13:12]), .pos8(posB[15:14]), .pos9(posB[17:16]),
      .sel_startX(sxB), .sel_endX(exB),
      .sel_startY(syB), .sel_endY(eyB),
      .turn(turnB), .winner(winB), .game_over(overB)
   );

   task automatic check(input string tag, input int got, input int exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which);
      bPlace = (which == 0);
      bUp    = (which == 1);
      bDown  = (which == 2);
      bLeft  = (which == 3);
      bRight = (which == 4);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 9; i++) mb[i] = 0;
      mr = 0; mc = 0; mturn = 0; mwin = 0; mover = 0;
   endtask

   function automatic int lineOf(input int m);
      int hit = 0;
      for (int i = 0; i < 3; i++) begin
         if (mb[3*i] == m && mb[3*i+1] == m && mb[3*i+2] == m) hit = 1;
         if (mb[i] == m && mb[i+3] == m && mb[i+6] == m) hit = 1;
      end
      if (mb[0] == m && mb[4] == m && mb[8] == m) hit = 1;
      if (mb[2] == m && mb[4] == m && mb[6] == m) hit = 1;
      return hit;
   endfunction

   function automatic int boardFull();
      int f = 1;
      for (int i = 0; i < 9; i++) if (mb[i] == 0) f = 0;
      return f;
   endfunction

   function automatic int boardVec();
      int v = 0;
      for (int i = 0; i < 9; i++) v = v | (mb[i] << (2*i));
      return v;
   endfunction

   task automatic checkAll(input string tag);
      check({tag, ".board"}, int'(posA), boardVec());
      check({tag, ".sx"}, int'(sxA), 213*mc);
      check({tag, ".ex"}, int'(exA), (mc == 2) ? 640 : 213*(mc+1));
      check({tag, ".sy"}, int'(syA), 160*mr);
      check({tag, ".ey"}, int'(eyA), 160*(mr+1));
      check({tag, ".turn"}, int'(turnA), mturn);
      check({tag, ".win"}, int'(winA), mwin);
      check({tag, ".over"}, int'(overA), mover);
   endtask

   task automatic step(input int which);
      int placed;
      int m;
      placed = 0;
      drive(which);
      tick();
      drive(-1);
      if (mover != 0) begin
         if (which == 0) modelReset();
      end else begin
         case (which)
            0: if (mb[mr*3+mc] == 0) begin
                  mb[mr*3+mc] = mturn + 1;
                  placed = 1;
               end
            1: mr = (mr + 2) % 3;
            2: mr = (mr + 1) % 3;
            3: mc = (mc + 2) % 3;
            4: mc = (mc + 1) % 3;
            default: ;
         endcase
      end
      checkAll("step");
      if (placed != 0) begin
         drive(int'($urandom_range(0, 4)));
         tick();
         drive(-1);
         m = mturn + 1;
         if (lineOf(m) != 0) begin
            mwin = m;
            mover = 1;
         end else if (boardFull() != 0) begin
            mover = 1;
         end else begin
            mturn = 1 - mturn;
         end
         checkAll("resolve");
      end
   endtask

   task automatic placeAt(input int idx);
      while (mc != idx % 3) step(4);
      while (mr != idx / 3) step(2);
      step(0);
   endtask

   task automatic resetA();
      rstA = 1'b1;
      tick();
      rstA = 1'b0;
      modelReset();
      checkAll("reset");
   endtask

   initial begin
      int r;
      int seqWin [5] = '{0, 3, 1, 4, 2};
      int seqDraw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

      modelReset();
      drive(-1);
      tick();
      tick();
      rstA = 1'b0;
      checkAll("reset");

      step(4); step(4); step(4);
      step(1);
      step(3);

      resetA();
      foreach (seqWin[i]) placeAt(seqWin[i]);
      check("win.x", int'(winA), 1);
      check("win.over", int'(overA), 1);
      step(4);
      step(0);
      check("newgame.over", int'(overA), 0);

      placeAt(4);
      step(0);
      check("occupied.turn", int'(turnA), 1);
      check("occupied.pos5", int'(posA[9:8]), 1);

      resetA();
      foreach (seqDraw[i]) placeAt(seqDraw[i]);
      check("draw.win", int'(winA), 0);
      check("draw.over", int'(overA), 1);
      step(0);

      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 7));
         if (r <= 1) step(0);
         else if (r <= 5) step(r - 1);
         else step(-1);
      end

      rstB = 1'b0;
      check("timer.reset.sx", int'(sxB), 0);
      for (int i = 0; i < 15; i++) tick();
      check("timer.early", int'(posB), 0);
      tick();
      check("timer.auto1", int'(posB), 1);
      tick();
      check("timer.turn", int'(turnB), 1);
      for (int i = 0; i < 15; i++) tick();
      check("timer.early2", int'(posB), 1);
      tick();
      check("timer.auto2", int'(posB), 9);
      tick();
      for (int i = 0; i < 5; i++) tick();
      rstB = 1'b1;
      tick();
      rstB = 1'b0;
      check("timer.rst.board", int'(posB), 0);
      check("timer.rst.turn", int'(turnB), 0);
      check("timer.rst.over", int'(overB), 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
